serial_add_sched: RTL and testbench

- Shares one SLICE-bit ripple adder slice between two requesters and sequences WIDTH-bit additions through it, one slice per cycle.
- A round-robin arbiter grants one requester, latches its operands and runs WIDTH/SLICE slice cycles with a registered carry.
- The result is returned on a valid/ready response channel tagged with the requester id.
- Area-reduced alternative to the full-width registered adder, for low-throughput address/counter arithmetic.

---
 rtl/serial_add_sched.sv | 190 +++++++++++++++++++
 tb/tb_serial_add_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// Serial adder scheduler: two requesters share one SLICE-bit adder slice and
// WIDTH-bit sums are built one slice per cycle, returned tagged with the requester id.

module serial_add_sched_chk #(
  parameter int WIDTH = 64
) (
  input logic             clk,
  input logic             rst,
  input logic             req0_ready,
  input logic             req1_ready,
  input logic             rsp_valid,
  input logic             rsp_ready,
  input logic [WIDTH-1:0] rsp_sum,
  input logic             rsp_cout,
  input logic             rsp_id,
  input logic             busy
);

  a_one_ready: assert property (@(posedge clk) disable iff (!rst)
    !(req0_ready && req1_ready));

  a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst)
    (req0_ready || req1_ready) |-> !busy);

  // A pending response must not move until the consumer takes it.
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable(rsp_sum) && $stable(rsp_cout) && $stable(rsp_id)));

endmodule

module serial_add_sched #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSL - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                 state_r;
  logic [CW-1:0]              cnt_r;
  logic                       carry_r;
  logic [NSL-1:0][SLICE-1:0]  a_r;
  logic [NSL-1:0][SLICE-1:0]  b_r;
  logic [NSL-1:0][SLICE-1:0]  sum_r;
  logic                       cout_r;
  logic                       id_r;
  logic                       rsp_valid_r;
  logic                       busy_r;
  // Id of the requester served last; resetting to 1 makes req0 win first contention.
  logic                       last_id_r;

  logic                       grant0_s;
  logic                       grant1_s;
  logic                       accept_s;
  logic                       accept_id_s;
  logic [SLICE-1:0]           a_slice_s;
  logic [SLICE-1:0]           b_slice_s;
  logic [SLICE-1:0]           slice_sum_s;
  logic                       slice_cout_s;

  // Round-robin grant, only offered while idle.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0_s = last_id_r;
        grant1_s = ~last_id_r;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;
  assign accept_s    = grant0_s | grant1_s;
  assign accept_id_s = grant1_s;

  // Shared slice adder working on slice cnt_r of the latched operands.
  always_comb begin
    a_slice_s = a_r[cnt_r];
    b_slice_s = b_r[cnt_r];
    {slice_cout_s, slice_sum_s} = {1'b0, a_slice_s} + {1'b0, b_slice_s}
                                  + {{SLICE{1'b0}}, carry_r};
  end

  // Sequencer: accept, run one slice per cycle, hold the result until consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      id_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      last_id_r   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
            cnt_r     <= '0;
            a_r       <= accept_id_s ? req1_a : req0_a;
            b_r       <= accept_id_s ? req1_b : req0_b;
            carry_r   <= accept_id_s ? req1_cin : req0_cin;
            id_r      <= accept_id_s;
            last_id_r <= accept_id_s;
          end
        end
        ST_RUN: begin
          sum_r[cnt_r] <= slice_sum_s;
          carry_r      <= slice_cout_s;
          cnt_r        <= cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_r     <= ST_DONE;
            rsp_valid_r <= 1'b1;
            cout_r      <= slice_cout_s;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;
  assign rsp_id    = id_r;
  assign busy      = busy_r;

  serial_add_sched_chk #(.WIDTH(WIDTH)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed plus randomized bench for serial_add_sched against a plain-arithmetic
// reference of a+b+cin, a served-last arbitration model and fixed latency rules.
module tb_serial_add_sched;

  localparam int WIDTH = 64;
  localparam int SLICE = 8;
  localparam int LAT   = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_cin = 1'b0, req1_cin = 1'b0;
  logic             rsp_valid, rsp_cout, rsp_id, busy;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_sum;

  int tests = 0;
  int fails = 0;
  bit last_id_m = 1'b1;
  logic [WIDTH-1:0] oa, ob;
  logic             oc;

  always #5 clk = ~clk;

  serial_add_sched #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {64'd0, cin};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [63:0] a, input logic [63:0] b, input logic c);
    if (id == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_cin = c; end
    else         begin req1_valid = v; req1_a = a; req1_b = b; req1_cin = c; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("reset_outs", {rsp_valid, rsp_cout, rsp_id, busy, req0_ready, req1_ready}, 6'd0);
    chk("reset_sum", {1'b0, rsp_sum}, 65'd0);
    @(negedge clk);
    rst = 1'b1;
    last_id_m = 1'b1;
  endtask

  task automatic wait_ready(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (((id == 0) ? req0_ready : req1_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("accept_req%0d", id), ok, 1'b1);
    chk("single_ready", {1'b0, (id == 0) ? req1_ready : req0_ready}, 2'd0);
  endtask

  // Call right after wait_ready: the accept happens on the coming posedge.
  task automatic finish(input int id, input logic [64:0] exp, input int hold, input bit other_on);
    int lat;
    bit busy_ok, stable_ok;
    @(negedge clk);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (other_on) set_req(1 - id, 1'b1, oa, ob, oc);
    rsp_ready = 1'b0;
    #1;
    lat = 0;
    busy_ok = 1'b1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      busy_ok &= (busy === 1'b1) && (req0_ready === 1'b0) && (req1_ready === 1'b0);
      @(negedge clk); #1;
      lat++;
    end
    chk("latency", lat, LAT);
    chk("busy_run_no_ready", busy_ok, 1'b1);
    chk("rsp_sum", {1'b0, rsp_sum}, {1'b0, exp[63:0]});
    chk("rsp_cout", rsp_cout, exp[64]);
    chk("rsp_id", rsp_id, id[0]);
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      stable_ok &= (rsp_valid === 1'b1) && ({rsp_cout, rsp_sum} === exp) && (rsp_id === id[0])
                   && (req0_ready === 1'b0) && (req1_ready === 1'b0) && (busy === 1'b1);
    end
    if (hold > 0) chk("hold_stable", stable_ok, 1'b1);
    rsp_ready = 1'b1;
    #1;
    chk("no_ready_in_done", {req0_ready, req1_ready}, 2'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("consumed", rsp_valid, 1'b0);
    last_id_m = id[0];
  endtask

  task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b, input logic c);
    bit ok;
    @(negedge clk);
    set_req(id, 1'b1, a, b, c);
    wait_ready(id, ok);
    if (ok) finish(id, ref_add(a, b, c), 0, 1'b0);
    else set_req(id, 1'b0, a, b, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] q_exp[$];
    int          q_id[$];
    logic [63:0] a0, b0, a1, b1;
    logic        c0, c1;
    int          cyc, resp, prev_acc, gid, refresh;
    bit          ok, never_both;
    logic [64:0] e;

    do_reset();

    // Directed arithmetic corners
    run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    run_op(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
    run_op(0, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 1'b0);
    for (int i = 0; i < 6; i++) run_op(i % 2, rnd64(), rnd64(), 1'($urandom_range(1, 0)));

    // Both requesters held valid: alternation, spacing, never two readys
    do_reset();
    rsp_ready = 1'b1;
    a0 = rnd64(); b0 = rnd64(); c0 = 1'($urandom_range(1, 0));
    a1 = rnd64(); b1 = rnd64(); c1 = 1'($urandom_range(1, 0));
    cyc = 0; resp = 0; prev_acc = -1; refresh = -1; never_both = 1'b1;
    while (resp < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (refresh == 0) begin a0 = rnd64(); b0 = rnd64(); c0 = 1'($urandom_range(1, 0)); end
      if (refresh == 1) begin a1 = rnd64(); b1 = rnd64(); c1 = 1'($urandom_range(1, 0)); end
      refresh = -1;
      set_req(0, 1'b1, a0, b0, c0);
      set_req(1, 1'b1, a1, b1, c1);
      #1;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) never_both = 1'b0;
      if (rsp_valid === 1'b1 && q_exp.size() > 0) begin
        e = q_exp.pop_front();
        gid = q_id.pop_front();
        chk($sformatf("rr_rsp%0d_id", resp), rsp_id, gid[0]);
        chk($sformatf("rr_rsp%0d_sum", resp), {rsp_cout, rsp_sum}, e);
        resp++;
      end
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        gid = (req1_ready === 1'b1) ? 1 : 0;
        chk("rr_grant", gid, last_id_m ? 0 : 1);
        q_exp.push_back((gid == 0) ? ref_add(a0, b0, c0) : ref_add(a1, b1, c1));
        q_id.push_back(gid);
        last_id_m = gid[0];
        if (prev_acc >= 0) chk("accept_spacing", cyc - prev_acc, LAT + 2);
        prev_acc = cyc;
        refresh = gid;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_responses", resp, 4);
    chk("never_both_ready", never_both, 1'b1);
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);

    // Back-pressure in DONE with req0 waiting
    a1 = rnd64(); b1 = rnd64(); c1 = 1'b1;
    oa = rnd64(); ob = rnd64(); oc = 1'b0;
    @(negedge clk);
    set_req(1, 1'b1, a1, b1, c1);
    wait_ready(1, ok);
    if (ok) begin
      finish(1, ref_add(a1, b1, c1), 5, 1'b1);
      chk("ready_after_consume", req0_ready, 1'b1);
      finish(0, ref_add(oa, ob, oc), 0, 1'b0);
    end else begin
      set_req(1, 1'b0, a1, b1, c1);
    end

    // Reset during RUN at cnt==3
    @(negedge clk);
    set_req(0, 1'b1, rnd64(), rnd64(), 1'b1);
    wait_ready(0, ok);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_outs", {rsp_valid, rsp_cout, rsp_id, busy}, 4'd0);
    chk("midrst_sum", {1'b0, rsp_sum}, 65'd0);
    @(negedge clk);
    rst = 1'b1;
    last_id_m = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b1;
    end
    chk("no_rsp_after_rst", ok, 1'b0);
    a0 = rnd64(); b0 = rnd64(); c0 = 1'b1;
    oa = rnd64(); ob = rnd64(); oc = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, a0, b0, c0);
    set_req(1, 1'b1, oa, ob, oc);
    #1;
    chk("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
    if (req0_ready === 1'b1) begin
      finish(0, ref_add(a0, b0, c0), 0, 1'b0);
      wait_ready(1, ok);
      if (ok) finish(1, ref_add(oa, ob, oc), 0, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
